mem_wb_hilo: RTL and testbench

Receiving end of the MEM stage output bundle: the MEM/WB pipeline register, the architectural HI/LO register pair and a retired-instruction counter in one block. Each cycle it captures destination/write-enable/data and HI/LO update fields from MEM, presents them to the register file as the WB stage, and commits HI/LO writes. It returns bypassed HI/LO values to EX and honours the pipeline stall/flush controller.

---
 rtl/mem_wb_hilo.sv | 83 ++++++++
 tb/tb_mem_wb_hilo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register, architectural HI/LO register pair with WB-stage
// bypass for EX, and a retired-instruction counter.
module mem_wb_hilo #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_mem,
   input  logic              stall_wb,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic              mem_wreg,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_whilo,
   input  logic [DATA_W-1:0] mem_hi,
   input  logic [DATA_W-1:0] mem_lo,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_wd,
   output logic              wb_wreg,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              wb_whilo,
   output logic [DATA_W-1:0] wb_hi,
   output logic [DATA_W-1:0] wb_lo,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic [DATA_W-1:0] hi_r;
   logic [DATA_W-1:0] lo_r;

   // WB register: reset and flush load a bubble, a lone MEM stall loads a
   // bubble while WB drains, otherwise capture MEM unless both stages hold.
   always_ff @(posedge clk) begin
      if (rst || flush || (stall_mem && !stall_wb)) begin
         wb_valid <= 1'b0;
         wb_wd    <= '0;
         wb_wreg  <= 1'b0;
         wb_wdata <= '0;
         wb_whilo <= 1'b0;
         wb_hi    <= '0;
         wb_lo    <= '0;
      end else if (!stall_mem) begin
         wb_valid <= mem_valid;
         wb_wd    <= mem_wd;
         wb_wreg  <= mem_wreg;
         wb_wdata <= mem_wdata;
         wb_whilo <= mem_whilo;
         wb_hi    <= mem_hi;
         wb_lo    <= mem_lo;
      end
   end

   // HI/LO commit from WB; a held WB write simply rewrites the same values.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (wb_whilo) begin
         hi_r <= wb_hi;
         lo_r <= wb_lo;
      end
   end

   // Read port for EX: the pending WB write wins so both halves stay paired.
   always_comb begin
      hi_o = wb_whilo ? wb_hi : hi_r;
      lo_o = wb_whilo ? wb_lo : lo_r;
   end

   // Count an instruction on the edge where it leaves WB; wraps freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if (wb_valid && !stall_wb) begin
         retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Directed bench for mem_wb_hilo; a second instance with a 4-bit counter
// exercises counter wrap-around.
module tb_mem_wb_hilo;

   logic        clk = 1'b0;
   logic        rst, stall_mem, stall_wb, flush;
   logic        mem_valid, mem_wreg, mem_whilo;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata, mem_hi, mem_lo;
   logic        wb_valid, wb_wreg, wb_whilo;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata, wb_hi, wb_lo, hi_o, lo_o, retire_cnt;
   logic        s_valid, s_wreg, s_whilo;
   logic [4:0]  s_wd;
   logic [31:0] s_wdata, s_hi, s_lo, s_hi_o, s_lo_o;
   logic [3:0]  s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_hilo dut (
      .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
      .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .hi_o(hi_o), .lo_o(lo_o), .retire_cnt(retire_cnt)
   );

   mem_wb_hilo #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
      .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .wb_valid(s_valid), .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
      .wb_whilo(s_whilo), .wb_hi(s_hi), .wb_lo(s_lo),
      .hi_o(s_hi_o), .lo_o(s_lo_o), .retire_cnt(s_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rst = 0; stall_mem = 0; stall_wb = 0; flush = 0;
      mem_valid = 0; mem_wd = 0; mem_wreg = 0; mem_wdata = 0;
      mem_whilo = 0; mem_hi = 0; mem_lo = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1; mem_valid = 1; mem_wreg = 1; mem_wd = 5'd12; mem_wdata = 32'hDEADBEEF;
      mem_whilo = 1; mem_hi = 32'h1234; mem_lo = 32'h5678;
      step();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", wb_valid); end
      n_checks++; if (wb_wd !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_wd: got %0d expected 0", wb_wd); end
      n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wreg: got %0b expected 0", wb_wreg); end
      n_checks++; if (wb_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wdata: got %h expected 0", wb_wdata); end
      n_checks++; if (wb_whilo !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_whilo: got %0b expected 0", wb_whilo); end
      n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi_o, lo_o); end
      n_checks++; if (retire_cnt !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", retire_cnt); end
      drive_idle();
   endtask

   task automatic test_pass_through();
      mem_valid = 1; mem_wd = 5'd5; mem_wreg = 1; mem_wdata = 32'h12345678;
      step();
      n_checks++; if (wb_wd !== 5'd5 || wb_wreg !== 1'b1 || wb_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_ctrl: got wd=%0d wreg=%0b valid=%0b expected 5/1/1", wb_wd, wb_wreg, wb_valid); end
      n_checks++; if (wb_wdata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL pass_wdata: got %h expected 12345678", wb_wdata); end
      n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL pass_cnt_early: got %0d expected 0", retire_cnt); end
      drive_idle();
      step();
      n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL pass_cnt: got %0d expected 1", retire_cnt); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_bubble: got %0b expected 0", wb_valid); end
   endtask

   task automatic test_hilo_bypass();
      mem_valid = 1; mem_whilo = 1; mem_hi = 32'hAAAA0001; mem_lo = 32'h55550002;
      step();
      n_checks++; if (hi_o !== 32'hAAAA0001 || lo_o !== 32'h55550002) begin n_fail++; $display("[TB] FAIL bypass: got %h/%h expected aaaa0001/55550002", hi_o, lo_o); end
      drive_idle();
      step();
      n_checks++; if (wb_whilo !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_drop: got %0b expected 0", wb_whilo); end
      n_checks++; if (hi_o !== 32'hAAAA0001 || lo_o !== 32'h55550002) begin n_fail++; $display("[TB] FAIL hilo_commit: got %h/%h expected aaaa0001/55550002", hi_o, lo_o); end
      n_checks++; if (retire_cnt !== 32'd2) begin n_fail++; $display("[TB] FAIL bypass_cnt: got %0d expected 2", retire_cnt); end
   endtask

   task automatic test_back_to_back();
      mem_valid = 1; mem_whilo = 1; mem_hi = 32'h00000001; mem_lo = 32'h00000002;
      step();
      n_checks++; if (hi_o !== 32'h1 || lo_o !== 32'h2) begin n_fail++; $display("[TB] FAIL b2b_first: got %h/%h expected 1/2", hi_o, lo_o); end
      mem_hi = 32'h00000003; mem_lo = 32'h00000004;
      step();
      n_checks++; if (hi_o !== 32'h3 || lo_o !== 32'h4) begin n_fail++; $display("[TB] FAIL b2b_second: got %h/%h expected 3/4", hi_o, lo_o); end
      drive_idle();
      step();
      n_checks++; if (hi_o !== 32'h3 || lo_o !== 32'h4) begin n_fail++; $display("[TB] FAIL b2b_final: got %h/%h expected 3/4", hi_o, lo_o); end
      n_checks++; if (retire_cnt !== 32'd4) begin n_fail++; $display("[TB] FAIL b2b_cnt: got %0d expected 4", retire_cnt); end
   endtask

   task automatic test_stall();
      mem_valid = 1; mem_wd = 5'd7; mem_wreg = 1; mem_wdata = 32'hCAFE0007;
      step();
      stall_mem = 1;
      step();
      n_checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL stall_bubble: got valid=%0b wreg=%0b wdata=%h expected 0/0/0", wb_valid, wb_wreg, wb_wdata); end
      n_checks++; if (retire_cnt !== 32'd5) begin n_fail++; $display("[TB] FAIL stall_drain_cnt: got %0d expected 5", retire_cnt); end
      stall_mem = 0; mem_wd = 5'd9; mem_wdata = 32'h00000099;
      step();
      stall_mem = 1; stall_wb = 1; mem_wd = 5'd1; mem_wdata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (wb_wd !== 5'd9 || wb_wdata !== 32'h99 || wb_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold%0d: got wd=%0d wdata=%h valid=%0b expected 9/99/1", i, wb_wd, wb_wdata, wb_valid); end
         n_checks++; if (retire_cnt !== 32'd5) begin n_fail++; $display("[TB] FAIL stall_hold_cnt%0d: got %0d expected 5", i, retire_cnt); end
      end
      drive_idle();
      step();
      n_checks++; if (retire_cnt !== 32'd6 || wb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release: got cnt=%0d valid=%0b expected 6/0", retire_cnt, wb_valid); end
   endtask

   task automatic test_flush();
      mem_valid = 1; mem_whilo = 1; mem_hi = 32'h11112222; mem_lo = 32'h33334444;
      step();
      flush = 1; stall_mem = 1; stall_wb = 1;
      mem_whilo = 0; mem_wreg = 1; mem_wd = 5'd3; mem_wdata = 32'h00000BAD;
      step();
      n_checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_whilo !== 1'b0 || wb_wd !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_bubble: got valid=%0b wreg=%0b whilo=%0b wd=%0d expected 0/0/0/0", wb_valid, wb_wreg, wb_whilo, wb_wd); end
      n_checks++; if (hi_o !== 32'h11112222 || lo_o !== 32'h33334444) begin n_fail++; $display("[TB] FAIL flush_commit: got %h/%h expected 11112222/33334444", hi_o, lo_o); end
      n_checks++; if (retire_cnt !== 32'd6) begin n_fail++; $display("[TB] FAIL flush_cnt: got %0d expected 6", retire_cnt); end
      drive_idle();
   endtask

   task automatic test_reset_mid_stall();
      mem_valid = 1; mem_whilo = 1; mem_hi = 32'h00000077; mem_lo = 32'h00000088;
      step();
      rst = 1; stall_mem = 1; stall_wb = 1; flush = 1;
      step();
      n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0 || wb_whilo !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_drop_hilo: got %h/%h whilo=%0b expected 0/0/0", hi_o, lo_o, wb_whilo); end
      n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_mid_cnt: got %0d expected 0", retire_cnt); end
      drive_idle();
   endtask

   task automatic test_wrap();
      mem_valid = 1; mem_wreg = 1; mem_wd = 5'd2;
      for (int i = 0; i < 16; i++) step();
      n_checks++; if (s_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL wrap_pre: got %0d expected 15", s_cnt); end
      drive_idle();
      step();
      n_checks++; if (s_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL wrap: got %0d expected 0", s_cnt); end
      n_checks++; if (retire_cnt !== 32'd16) begin n_fail++; $display("[TB] FAIL wrap_wide: got %0d expected 16", retire_cnt); end
   endtask

   // Scenario sequence.
   initial begin
      drive_idle();
      rst = 1;
      step();
      test_reset();
      test_pass_through();
      test_hilo_bypass();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid_stall();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
